// File: rtl/tw_mult_pre.sv
// rtl/tw_mult_pre.sv - twiddle address generation and residue x twiddle multiply ahead of Barrett reduction
// Optional macro TW_PIPE_EXTRA_EN adds one register stage after the multiplier.
module tw_mult_pre #(
  parameter int          DATA_WIDTH        = 22,
  parameter int          DOUBLE_DATA_WIDTH = 44,
  parameter int unsigned PRIME             = 2146043,
  parameter int          FFT_POINT         = 16384,
  parameter int          ADDR_WIDTH        = 14,
  parameter int          BR_LATENCY        = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic [ADDR_WIDTH-1:0]        tw_addr,
  input  logic [DATA_WIDTH-1:0]        tw_data,
  output logic [DOUBLE_DATA_WIDTH-1:0] S_out,
  output logic                         mult_valid,
  output logic                         br_valid,
  output logic                         busy,
  output logic                         frame_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FFT_POINT - 1);

  if (64'(PRIME) >= (64'(1) << DATA_WIDTH)) begin : g_prime_check
    $error("PRIME does not fit in DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    frame_start;
  logic                    accept;
  logic                    last_accept;

  logic                    vld_d1, vld_d2, last_d1, last_d2;
  logic [DATA_WIDTH-1:0]   data_d1, data_d2;
  logic [DOUBLE_DATA_WIDTH-1:0] product;
  logic [DOUBLE_DATA_WIDTH-1:0] s_src;
  logic                    s_vld, s_last;
  logic                    mult_last;
  logic [BR_LATENCY-1:0]   br_vld_sr, br_last_sr;

  assign accept      = (state == RUN) && in_valid;
  assign last_accept = accept && (cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b1;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          frame_start = 1'b1;
          state_nxt   = RUN;
        end
      end
      RUN:     if (last_accept) state_nxt = DRAIN;
      DRAIN:   if (frame_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (frame_start) cnt <= '0;
    else if (accept)      cnt <= cnt + ADDR_WIDTH'(1);
  end

  // Address is n_lo * n_hi; operands widened so the 4x10 product keeps all 14 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_addr <= '0;
      data_d1 <= '0;
      data_d2 <= '0;
      vld_d1  <= 1'b0;
      vld_d2  <= 1'b0;
      last_d1 <= 1'b0;
      last_d2 <= 1'b0;
    end else begin
      vld_d1  <= accept;
      last_d1 <= last_accept;
      vld_d2  <= vld_d1;
      last_d2 <= last_d1;
      if (accept) begin
        tw_addr <= ADDR_WIDTH'(cnt[3:0]) * ADDR_WIDTH'(cnt[ADDR_WIDTH-1:4]);
        data_d1 <= in_data;
      end
      if (vld_d1) data_d2 <= data_d1;
    end
  end

  assign product = DOUBLE_DATA_WIDTH'(data_d2) * DOUBLE_DATA_WIDTH'(tw_data);

`ifdef TW_PIPE_EXTRA_EN
  logic [DOUBLE_DATA_WIDTH-1:0] prod_q;
  logic                         prod_vld, prod_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q    <= '0;
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
    end else begin
      prod_vld  <= vld_d2;
      prod_last <= last_d2;
      if (vld_d2) prod_q <= product;
    end
  end

  assign s_src  = prod_q;
  assign s_vld  = prod_vld;
  assign s_last = prod_last;
`else
  assign s_src  = product;
  assign s_vld  = vld_d2;
  assign s_last = last_d2;
`endif

  // S_out keeps the last product across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S_out      <= '0;
      mult_valid <= 1'b0;
      mult_last  <= 1'b0;
    end else begin
      mult_valid <= s_vld;
      mult_last  <= s_last;
      if (s_vld) S_out <= s_src;
    end
  end

  // Mirrors the reduction stage latency so br_valid and frame_done align with its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_vld_sr  <= '0;
      br_last_sr <= '0;
    end else begin
      br_vld_sr[0]  <= mult_valid;
      br_last_sr[0] <= mult_valid && mult_last;
      for (int i = 1; i < BR_LATENCY; i++) begin
        br_vld_sr[i]  <= br_vld_sr[i-1];
        br_last_sr[i] <= br_last_sr[i-1];
      end
    end
  end

  assign br_valid   = br_vld_sr[BR_LATENCY-1];
  assign frame_done = br_last_sr[BR_LATENCY-1];

endmodule
